// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-ported data SRAM.
// Port 0 is the CPU load/store unit, port 1 the program loader / debug port.
// One access is in flight at a time and takes three cycles (IDLE, ACCESS, RESP).
//
// Handshake (both requester ports): the requester raises pN_req with a stable
// command and holds it until it sees pN_gnt. pN_gnt is a one-cycle pulse that
// marks the cycle the SRAM is driven; pN_done is a one-cycle pulse on the
// following cycle, qualifying pN_rdata and pN_err. A req still high in the
// IDLE cycle after done is a fresh request. req is only sampled in IDLE.
module dmem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int MEM_BYTES = 65536,
   parameter int FIXED_PRI = 0
) (
   input  logic              clk,
   input  logic              rst,
   // port 0
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [31:0]       p0_wdata,
   input  logic [3:0]        p0_wstrb,
   output logic              p0_gnt,
   output logic              p0_done,
   output logic [31:0]       p0_rdata,
   output logic              p0_err,
   // port 1
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [31:0]       p1_wdata,
   input  logic [3:0]        p1_wstrb,
   output logic              p1_gnt,
   output logic              p1_done,
   output logic [31:0]       p1_rdata,
   output logic              p1_err,
   // SRAM
   output logic              mem_cs,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   // debug: current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // One bit wider than the address so MEM_BYTES == 2**ADDR_W is still representable.
   localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;   // port that owns the access in flight
   logic              pri_q,   pri_d;     // port favoured on the next tie
   logic              we_q,    we_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;

   logic              winner;
   logic              in_range;

   assign in_range  = ({1'b0, addr_q} < MEM_LIMIT);
   assign dbg_state = state_q;

   // State and latched command registers; reset aborts any access in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         pri_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         pri_q   <= pri_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
      end
   end

   // Next-state, arbitration and all outputs; every output is zero in IDLE.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      pri_d     = pri_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      winner    = 1'b0;
      p0_gnt    = 1'b0;
      p1_gnt    = 1'b0;
      p0_done   = 1'b0;
      p1_done   = 1'b0;
      p0_rdata  = '0;
      p1_rdata  = '0;
      p0_err    = 1'b0;
      p1_err    = 1'b0;
      mem_cs    = 1'b0;
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;

      case (state_q)
         IDLE: begin
            if (p0_req || p1_req) begin
               if (FIXED_PRI != 0) begin
                  winner = !p0_req;
               end else if (p0_req && p1_req) begin
                  winner = pri_q;
               end else begin
                  winner = p1_req;
               end
               owner_d = winner;
               we_d    = winner ? p1_we    : p0_we;
               addr_d  = winner ? p1_addr  : p0_addr;
               wdata_d = winner ? p1_wdata : p0_wdata;
               wstrb_d = winner ? p1_wstrb : p0_wstrb;
               state_d = ACCESS;
            end
         end

         ACCESS: begin
            p0_gnt    = !owner_q;
            p1_gnt    = owner_q;
            // Out-of-range accesses are still granted but never reach the SRAM.
            mem_cs    = in_range;
            mem_we    = (in_range && we_q) ? wstrb_q : 4'b0000;
            mem_addr  = addr_q[ADDR_W-1:2];
            mem_wdata = wdata_q;
            pri_d     = !owner_q;
            state_d   = RESP;
         end

         RESP: begin
            p0_done  = !owner_q;
            p1_done  = owner_q;
            p0_rdata = (!owner_q && in_range) ? mem_rdata : 32'h0;
            p1_rdata = ( owner_q && in_range) ? mem_rdata : 32'h0;
            p0_err   = !owner_q && !in_range;
            p1_err   =  owner_q && !in_range;
            state_d  = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
